// File: rtl/wb_sched.sv
// Write-back scheduler: register scoreboard with issue stall and round-robin grant for ALU/MEM/MDU.
// Latency: one cycle from grant to the register-file write port, and two cycles from grant to the cleared stall.
// Backpressure: requesters hold their request until wb_ready, and ID holds while stall is high.
module wb_sched #(
  parameter int XLEN = 32,
  parameter int NREQ = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iss_valid,
  input  logic [4:0]                 iss_rd,
  input  logic                       iss_wr,
  input  logic [4:0]                 id_rs1,
  input  logic [4:0]                 id_rs2,
  output logic                       stall,
  input  logic [NREQ-1:0]            wb_valid,
  input  logic [NREQ-1:0][4:0]       wb_rd,
  input  logic [NREQ-1:0][XLEN-1:0]  wb_data,
  output logic [NREQ-1:0]            wb_ready,
  output logic                       reg_write,
  output logic [4:0]                 wt_addr,
  output logic [XLEN-1:0]            wt_data,
  output logic [31:0]                busy,
  output logic                       err_orphan
);

  logic [1:0]  ptr;        // last granted requester
  logic        gnt_vld;    // a grant is issued this cycle
  logic [1:0]  gnt_idx;
  logic [4:0]  gnt_rd;
  logic        iss_acc;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  // Round-robin selection: search starts at the requester after the last grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    case (ptr)
      2'd0: begin
        if (wb_valid[1])      begin gnt_vld = 1'b1; gnt_idx = 2'd1; end
        else if (wb_valid[2]) begin gnt_vld = 1'b1; gnt_idx = 2'd2; end
        else if (wb_valid[0]) begin gnt_vld = 1'b1; gnt_idx = 2'd0; end
      end
      2'd1: begin
        if (wb_valid[2])      begin gnt_vld = 1'b1; gnt_idx = 2'd2; end
        else if (wb_valid[0]) begin gnt_vld = 1'b1; gnt_idx = 2'd0; end
        else if (wb_valid[1]) begin gnt_vld = 1'b1; gnt_idx = 2'd1; end
      end
      default: begin
        if (wb_valid[0])      begin gnt_vld = 1'b1; gnt_idx = 2'd0; end
        else if (wb_valid[1]) begin gnt_vld = 1'b1; gnt_idx = 2'd1; end
        else if (wb_valid[2]) begin gnt_vld = 1'b1; gnt_idx = 2'd2; end
      end
    endcase
    // Nothing is granted while reset is held.
    if (rst) gnt_vld = 1'b0;
  end

  assign gnt_rd   = wb_rd[gnt_idx];
  assign wb_ready = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;

  // Hazard check against the scoreboard; x0 never has its busy bit set.
  assign stall   = busy[id_rs1] | busy[id_rs2] | (iss_valid & iss_wr & busy[iss_rd]);
  assign iss_acc = iss_valid & ~stall & ~rst;
  assign set_vec = (iss_acc && iss_wr && iss_rd != 5'd0) ? (32'd1 << iss_rd) : 32'd0;
  assign clr_vec = reg_write ? (32'd1 << wt_addr) : 32'd0;

  // Scoreboard update: set on issue, clear with the register-file write; set wins.
  always_ff @(posedge clk) begin
    if (rst) busy <= 32'd0;
    else     busy <= ((busy & ~clr_vec) | set_vec) & ~32'd1;
  end

  // Registered write port; a grant to x0 is consumed without a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write <= 1'b0;
      wt_addr   <= 5'd0;
      wt_data   <= '0;
    end else if (gnt_vld && gnt_rd != 5'd0) begin
      reg_write <= 1'b1;
      wt_addr   <= gnt_rd;
      wt_data   <= wb_data[gnt_idx];
    end else begin
      reg_write <= 1'b0;
    end
  end

  // Arbitration pointer: follows the last grant, reset makes requester 0 first.
  always_ff @(posedge clk) begin
    if (rst)          ptr <= 2'd2;
    else if (gnt_vld) ptr <= gnt_idx;
  end

  // Sticky flag for a write-back whose destination was never marked busy.
  always_ff @(posedge clk) begin
    if (rst)                                        err_orphan <= 1'b0;
    else if (gnt_vld && gnt_rd != 5'd0 && !busy[gnt_rd]) err_orphan <= 1'b1;
  end

endmodule

// File: tb/tb_wb_sched.sv
// Bench for wb_sched: directed vector table, a cycle scoreboard of the write port, and a random arbitration phase.
// The scoreboard predicts each cycle's write-port outputs one cycle ahead and checks them when the cycle arrives.
// Requesters in the random phase hold their request until they see wb_ready.
module tb_wb_sched;

  logic              clk = 1'b0;
  logic              rst;
  logic              iss_valid;
  logic [4:0]        iss_rd;
  logic              iss_wr;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic              stall;
  logic [2:0]        wb_valid;
  logic [2:0][4:0]   wb_rd;
  logic [2:0][31:0]  wb_data;
  logic [2:0]        wb_ready;
  logic              reg_write;
  logic [4:0]        wt_addr;
  logic [31:0]       wt_data;
  logic [31:0]       busy;
  logic              err_orphan;

  always #5 clk = ~clk;

  wb_sched #(.XLEN(32), .NREQ(3)) dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_wr(iss_wr),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_ready(wb_ready), .reg_write(reg_write), .wt_addr(wt_addr),
    .wt_data(wt_data), .busy(busy), .err_orphan(err_orphan)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic        mon_en = 1'b0;
  logic [31:0] m_busy;
  logic [1:0]  m_ptr;
  logic        m_err;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  always @(negedge clk) begin
    if (mon_en) begin
      wr_t         cur;
      wr_t         nxt;
      int          g;
      int          idx;
      logic        e_stall;
      logic [2:0]  e_rdy;
      logic [31:0] setv;
      logic [31:0] clrv;
      cur = '{1'b0, 5'd0, 32'd0};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        cur = exp_q.pop_front();
      end
      chk("reg_write", {31'd0, reg_write}, {31'd0, cur.we});
      chk("wt_addr", {27'd0, wt_addr}, {27'd0, cur.addr});
      chk("wt_data", wt_data, cur.data);
      chk("busy", busy, m_busy);
      chk("err_orphan", {31'd0, err_orphan}, {31'd0, m_err});
      e_stall = m_busy[id_rs1] | m_busy[id_rs2] | (iss_valid & iss_wr & m_busy[iss_rd]);
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      g = -1;
      if (!rst) begin
        for (int k = 1; k <= 3; k++) begin
          idx = (int'(m_ptr) + k) % 3;
          if (g < 0 && wb_valid[idx]) g = idx;
        end
      end
      e_rdy = (g < 0) ? 3'b000 : (3'b001 << g);
      chk("wb_ready", {29'd0, wb_ready}, {29'd0, e_rdy});
      if (rst) begin
        m_busy = 32'd0; m_ptr = 2'd2; m_err = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        nxt = '{1'b0, 5'd0, 32'd0};
      end else begin
        clrv = cur.we ? (32'd1 << cur.addr) : 32'd0;
        setv = (iss_valid && !e_stall && iss_wr && iss_rd != 5'd0) ? (32'd1 << iss_rd) : 32'd0;
        checks++;
        if ((setv & clrv) != 32'd0) begin
          failures++;
          $display("FAIL set_clear_same_bit: got %h expected 00000000", setv & clrv);
        end
        nxt = '{1'b0, m_addr, m_data};
        if (g >= 0) begin
          m_ptr = 2'(g);
          if (wb_rd[g] != 5'd0) begin
            if (!m_busy[wb_rd[g]]) m_err = 1'b1;
            m_addr = wb_rd[g];
            m_data = wb_data[g];
            nxt = '{1'b1, m_addr, m_data};
          end
        end
        m_busy = ((m_busy & ~clrv) | setv) & ~32'd1;
      end
      exp_q.push_back(nxt);
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r, iv;
    logic [4:0]  ird;
    logic        iwr;
    logic [4:0]  rs1, rs2;
    logic [2:0]  wv;
    logic [4:0]  rd0, rd1, rd2;
    logic [31:0] wd0;
    logic        e_stall;
    logic [2:0]  e_rdy;
  } vec_t;

  localparam int NV = 35;
  vec_t tbl[NV];

  function automatic vec_t v(input logic r, input logic iv, input logic [4:0] ird, input logic iwr,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] wv,
                             input logic [4:0] rd0, input logic [4:0] rd1, input logic [4:0] rd2,
                             input logic [31:0] wd0, input logic es, input logic [2:0] er);
    vec_t t;
    t = '{r, iv, ird, iwr, rs1, rs2, wv, rd0, rd1, rd2, wd0, es, er};
    return t;
  endfunction

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_rd = 5'd0; iss_wr = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    wb_valid = 3'b000; wb_rd = '0; wb_data = '0;
  endtask

  logic [2:0]  pend;
  logic [2:0]  rdy_s;

  initial begin
    // Row: rst iv ird iwr rs1 rs2 wv rd0 rd1 rd2 wd0 exp_stall exp_rdy
    tbl[0]  = v(1,0,0,0, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[1]  = v(0,1,5,1, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);  // issue rd=5
    tbl[2]  = v(0,0,0,0, 5,0, 3'b000, 0,0,0, 32'h0, 1,3'b000);  // dependent read stalls
    tbl[3]  = v(0,0,0,0, 5,0, 3'b010, 0,5,0, 32'h0, 1,3'b010);  // MEM wb rd=5 granted (N)
    tbl[4]  = v(0,0,0,0, 5,0, 3'b000, 0,0,0, 32'h0, 1,3'b000);  // write presented (N+1)
    tbl[5]  = v(0,0,0,0, 5,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);  // unstalled (N+2)
    tbl[6]  = v(0,1,7,1, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);  // issue rd=7
    tbl[7]  = v(0,1,7,1, 0,0, 3'b000, 0,0,0, 32'h0, 1,3'b000);  // WAW on busy rd=7 stalls
    tbl[8]  = v(0,0,0,0, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[9]  = v(0,0,0,0, 0,0, 3'b001, 0,0,0, 32'hDEADBEEF, 0,3'b001);  // ALU wb to x0
    tbl[10] = v(0,0,0,0, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[11] = v(0,0,0,0, 0,0, 3'b100, 0,0,9, 32'h0, 0,3'b100);  // orphan wb rd=9
    tbl[12] = v(0,0,0,0, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[13] = v(0,0,0,0, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[14] = v(1,0,0,0, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[15] = v(0,1,1,1, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[16] = v(0,1,2,1, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[17] = v(0,1,3,1, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[18] = v(0,0,0,0, 0,0, 3'b111, 1,2,3, 32'h0, 0,3'b001);  // round robin 0,1,2,0
    tbl[19] = v(0,0,0,0, 0,0, 3'b111, 0,2,3, 32'h0, 0,3'b010);
    tbl[20] = v(0,0,0,0, 0,0, 3'b111, 0,0,3, 32'h0, 0,3'b100);
    tbl[21] = v(0,0,0,0, 0,0, 3'b111, 0,0,0, 32'h0, 0,3'b001);
    tbl[22] = v(0,0,0,0, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[23] = v(0,1,4,1, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[24] = v(0,1,6,1, 0,0, 3'b010, 0,4,0, 32'h0, 0,3'b010);  // grant in flight at reset
    tbl[25] = v(1,0,0,0, 0,0, 3'b010, 0,4,0, 32'h0, 0,3'b000);  // no grant during reset
    tbl[26] = v(0,0,0,0, 0,0, 3'b011, 0,0,0, 32'h0, 0,3'b001);  // requester 0 first after reset
    tbl[27] = v(0,0,0,0, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[28] = v(0,1,3,1, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[29] = v(0,0,0,0, 0,3, 3'b000, 0,0,0, 32'h0, 1,3'b000);  // rs2 hazard
    tbl[30] = v(0,0,0,0, 0,3, 3'b001, 3,0,0, 32'h0, 1,3'b001);
    tbl[31] = v(0,0,0,0, 0,3, 3'b000, 0,0,0, 32'h0, 1,3'b000);
    tbl[32] = v(0,0,0,0, 0,3, 3'b000, 0,0,0, 32'h0, 0,3'b000);
    tbl[33] = v(0,1,3,0, 0,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);  // no-write issue sets nothing
    tbl[34] = v(0,0,0,0, 3,0, 3'b000, 0,0,0, 32'h0, 0,3'b000);

    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_busy = 32'd0; m_ptr = 2'd2; m_err = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    exp_q.push_back('{1'b0, 5'd0, 32'd0});
    mon_en = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      rst       = tbl[i].r;
      iss_valid = tbl[i].iv;
      iss_rd    = tbl[i].ird;
      iss_wr    = tbl[i].iwr;
      id_rs1    = tbl[i].rs1;
      id_rs2    = tbl[i].rs2;
      wb_valid  = tbl[i].wv;
      wb_rd[0]  = tbl[i].rd0;
      wb_rd[1]  = tbl[i].rd1;
      wb_rd[2]  = tbl[i].rd2;
      wb_data[0] = tbl[i].wd0;
      wb_data[1] = 32'h1111_0000 + 32'(i);
      wb_data[2] = 32'h2222_0000 + 32'(i);
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].e_stall});
      chk($sformatf("tbl%0d_rdy", i), {29'd0, wb_ready}, {29'd0, tbl[i].e_rdy});
    end

    // Random arbitration traffic; no issue, so only the scoreboard model judges.
    pend = 3'b000;
    rdy_s = 3'b000;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      iss_valid = 1'b0;
      id_rs1 = 5'($urandom_range(0, 31));
      id_rs2 = 5'($urandom_range(0, 31));
      for (int j = 0; j < 3; j++) begin
        if (pend[j] && rdy_s[j]) pend[j] = 1'b0;
        if (!pend[j] && $urandom_range(0, 1) == 1) begin
          pend[j] = 1'b1;
          wb_rd[j] = 5'($urandom_range(0, 31));
          wb_data[j] = $urandom;
        end
      end
      wb_valid = pend;
      @(negedge clk);
      rdy_s = wb_ready;
    end

    // Reset clears the sticky error and scoreboard, then an MDU write-back round trip.
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("seq_rst_rdy", {29'd0, wb_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("seq_err_cleared", {31'd0, err_orphan}, 32'd0);
    chk("seq_busy_cleared", busy, 32'd0);
    @(posedge clk); #1;
    iss_valid = 1'b1; iss_rd = 5'd12; iss_wr = 1'b1;
    @(posedge clk); #1;
    iss_valid = 1'b0; id_rs1 = 5'd12;
    wb_valid = 3'b100; wb_rd[2] = 5'd12; wb_data[2] = 32'hCAFE_F00D;
    @(negedge clk);
    chk("seq_mdu_grant", {29'd0, wb_ready}, 32'h4);
    chk("seq_stall_n", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    wb_valid = 3'b000;
    @(negedge clk);
    chk("seq_we_n1", {31'd0, reg_write}, 32'd1);
    chk("seq_addr_n1", {27'd0, wt_addr}, 32'd12);
    chk("seq_data_n1", wt_data, 32'hCAFE_F00D);
    chk("seq_stall_n1", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("seq_stall_n2", {31'd0, stall}, 32'd0);
    chk("seq_busy_n2", busy, 32'd0);

    @(posedge clk); #1;
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_sched.md
WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the write-back data width.
REQ-002 The block SHALL have parameter NREQ, fixed at 3, meaning the number of write-back requesters (0=ALU, 1=MEM, 2=MDU).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 The block SHALL have port iss_valid, input, 1, meaning an instruction in ID requests issue.
REQ-006 The block SHALL have port iss_rd, input, 5, meaning the destination register of the issuing instruction.
REQ-007 The block SHALL have port iss_wr, input, 1, meaning the issuing instruction writes a register.
REQ-008 The block SHALL have ports id_rs1 and id_rs2, input, 5 each, meaning the source registers of the instruction in ID.
REQ-009 The block SHALL have port stall, output, 1, meaning ID must hold and issue is not accepted.
REQ-010 The block SHALL have ports wb_valid, input, 3, meaning one write-back request bit per requester.
REQ-011 The block SHALL have ports wb_rd, input, 3x5, meaning the per-requester destination.
REQ-012 The block SHALL have ports wb_data, input, 3xXLEN, meaning the per-requester write data.
REQ-013 The block SHALL have ports wb_ready, output, 3, meaning the one-hot grant.
REQ-014 The block SHALL have ports reg_write, wt_addr, and wt_data, output, 1/5/XLEN, meaning the register-file write port (registered).
REQ-015 The block SHALL have port busy, output, 32, meaning the scoreboard; bit 0 is always 0.
REQ-016 The block SHALL have port err_orphan, output, 1, a sticky flag for a write-back to a non-busy register.

Function
REQ-017 stall SHALL equal (busy[id_rs1] | busy[id_rs2] | (iss_valid & iss_wr & busy[iss_rd])), combinationally; x0 is never busy.
REQ-018 Issue SHALL be accepted when iss_valid & !stall; if iss_wr and iss_rd!=0, busy[iss_rd] SHALL set at that edge.
REQ-019 Arbitration SHALL be round-robin: a 2-bit pointer holds the last granted requester, and priority starts at pointer+1 mod 3.
REQ-020 At most one wb_ready bit SHALL be high per cycle, and only to a requester whose wb_valid is high; wb_ready is combinational from wb_valid and the pointer.
REQ-021 The pointer SHALL update to the granted index on any grant, and SHALL hold when there is no grant.
REQ-022 A grant in cycle N SHALL load reg_write=1, wt_addr=wb_rd[g], wt_data=wb_data[g] for cycle N+1; with no grant, reg_write SHALL be 0 in N+1 and wt_addr/wt_data SHALL hold.
REQ-023 busy[wt_addr] SHALL clear at the end of cycle N+1 when reg_write=1 (same edge as the register-file write), so a dependent read is unstalled in cycle N+2.
REQ-024 A granted request with wb_rd=0 SHALL be accepted, SHALL produce reg_write=0, and SHALL not affect busy.
REQ-025 A granted request with wb_rd!=0 and busy[wb_rd]=0 SHALL still be written and SHALL set err_orphan, which holds until rst.
REQ-026 Set and clear of the same busy bit at one edge SHALL resolve to set. This is unreachable when REQ-017 is obeyed, and the bench asserts it never occurs.
REQ-027 Requesters SHALL hold wb_valid/wb_rd/wb_data until granted; the block SHALL not buffer ungranted requests.
REQ-028 Latency SHALL be one cycle from grant to write-port presentation and two cycles from grant to the cleared stall; throughput is one write-back per cycle.

Reset
REQ-029 With rst high at a clock edge, the following SHALL apply next cycle: busy=0, reg_write=0, wt_addr=0, wt_data=0, err_orphan=0, pointer=2 (requester 0 has first priority).
REQ-030 During rst, wb_ready SHALL be 0 and issue SHALL not be accepted; an in-flight write in the output register is discarded.
REQ-031 Reset asserted mid-operation SHALL drop all pending scoreboard entries; no write-back for them is expected afterwards.

Verification
REQ-032 Issue rd=5, then id_rs1=5 -> stall=1 until MEM wb rd=5 granted in cycle N; reg_write=1/wt_addr=5 in N+1; stall=0 in N+2.
REQ-033 All three wb_valid held high from reset, rd=1/2/3 busy -> grants in order 0,1,2,0..., one per cycle, and wt_addr sequence 1,2,3.
REQ-034 Issue rd=7 while busy[7]=1 -> stall=1, busy unchanged, and no double set.
REQ-035 ALU wb rd=0 data=0xDEADBEEF -> wb_ready[0]=1, reg_write=0 next cycle, busy unchanged, err_orphan=0.
REQ-036 wb rd=9 with busy[9]=0 -> write presented, err_orphan=1, and it persists until rst.
REQ-037 Issue rd=4 and rd=6, then rst for one cycle -> busy=0, reg_write=0, and the next grant goes to requester 0.
